// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//   Fractional baud generator. A runtime-loadable divisor (integer part plus a
//   FRAC_W-bit fraction) sets the oversample period in clk cycles. A fractional
//   accumulator stretches some periods by one clock so that the average period
//   equals div_int + div_frac/2^FRAC_W. Every OVERSAMPLE oversample ticks make
//   one bit tick. The bit phase can be restarted with resync.
//
//   Optional feature macro: BAUD_MID_TICK_EN
//     defined     : mid_tick pulses with the os_tick on which os_idx becomes
//                   OVERSAMPLE/2 (centre of the bit, for RX sampling)
//     not defined : mid_tick is tied low and has no logic behind it
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   en           in   1 = run, 0 = counters held cleared
//   resync       in   1-cycle pulse, restart the bit phase
//   div_load     in   1-cycle pulse, capture div_int_in / div_frac_in
//   div_int_in   in   [DIV_W-1:0]  integer divisor (clk per os_tick)
//   div_frac_in  in   [FRAC_W-1:0] fractional divisor (1/2^FRAC_W units)
//   div_pending  out  loaded divisor waiting for the next period boundary
//   os_tick      out  1-cycle pulse per oversample period
//   baud_tick    out  1-cycle pulse per bit, with the os_tick that wraps os_idx
//   os_idx       out  [$clog2(OVERSAMPLE)-1:0] os_tick index within the bit
//   mid_tick     out  1-cycle pulse at bit centre (see macro above)
// -----------------------------------------------------------------------------
module baud_gen_frac #(
  parameter int unsigned FRE        = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_int_in,
  input  logic [FRAC_W-1:0]             div_frac_in,
  output logic                          div_pending,
  output logic                          os_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_idx,
  output logic                          mid_tick
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);

  // Reset divisor: FRE/(BAUD_RATE*OVERSAMPLE) as a rounded fixed-point number
  // with FRAC_W fraction bits. Rounding the fraction up to 2^FRAC_W rolls the
  // carry into the integer part instead of wrapping the fraction to zero.
  localparam longint unsigned DEN     = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
  localparam longint unsigned DEF_FIX = ((longint'(FRE) << FRAC_W) + (DEN / 2)) / DEN;
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_FIX >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FIX);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);

  // Clamp a requested divisor: the counter needs at least 2 clocks per period,
  // and at the minimum of 2 a fractional stretch is not allowed.
  function automatic logic [DIV_W+FRAC_W-1:0] clamp_div(
    input logic [DIV_W-1:0]  int_in,
    input logic [FRAC_W-1:0] frac_in
  );
    logic [DIV_W-1:0]  int_c;
    logic [FRAC_W-1:0] frac_c;
    if (int_in <= DIV_W'(2)) begin
      int_c  = DIV_W'(2);
      frac_c = {FRAC_W{1'b0}};
    end else begin
      int_c  = int_in;
      frac_c = frac_in;
    end
    return {int_c, frac_c};
  endfunction

  // State registers
  logic [DIV_W-1:0]  cnt_r;
  logic [FRAC_W-1:0] frac_acc_r;
  logic [IDX_W-1:0]  os_idx_r;
  logic [DIV_W-1:0]  act_int_r;
  logic [FRAC_W-1:0] act_frac_r;
  logic [DIV_W-1:0]  sh_int_r;
  logic [FRAC_W-1:0] sh_frac_r;
  logic              pending_r;
  logic              os_tick_r;
  logic              baud_tick_r;

  // Next-state signals
  logic [DIV_W-1:0]  cnt_s;
  logic [FRAC_W-1:0] frac_acc_s;
  logic [IDX_W-1:0]  os_idx_s;
  logic [DIV_W-1:0]  act_int_s;
  logic [FRAC_W-1:0] act_frac_s;
  logic [DIV_W-1:0]  sh_int_s;
  logic [FRAC_W-1:0] sh_frac_s;
  logic              pending_s;
  logic              os_tick_s;
  logic              baud_tick_s;

  // Helpers
  logic [DIV_W-1:0]  ld_int_s;
  logic [FRAC_W-1:0] ld_frac_s;
  logic [FRAC_W:0]   sum_s;
  logic              carry_s;
  logic              period_end_s;

  assign {ld_int_s, ld_frac_s} = clamp_div(div_int_in, div_frac_in);

  // The carry of this period's accumulation decides whether the period is
  // stretched by one clock; frac_acc only moves on at the period end.
  assign sum_s   = {1'b0, frac_acc_r} + {1'b0, act_frac_r};
  assign carry_s = sum_s[FRAC_W];

  // Last cycle of the period: cnt == div_int + carry - 1, compared one bit
  // wider so that div_int + carry cannot overflow.
  assign period_end_s = (({1'b0, cnt_r} + (DIV_W+1)'(1)) ==
                         ({1'b0, act_int_r} + (DIV_W+1)'(carry_s)));

  // Next-state logic, priority: !en > resync > pending apply > normal count
  always_comb begin
    cnt_s       = cnt_r;
    frac_acc_s  = frac_acc_r;
    os_idx_s    = os_idx_r;
    act_int_s   = act_int_r;
    act_frac_s  = act_frac_r;
    sh_int_s    = sh_int_r;
    sh_frac_s   = sh_frac_r;
    pending_s   = pending_r;
    os_tick_s   = 1'b0;
    baud_tick_s = 1'b0;

    if (!en || resync) begin
      // Phase restart: a new divisor can take effect right away because no
      // period is in progress to be truncated or extended.
      cnt_s      = {DIV_W{1'b0}};
      frac_acc_s = {FRAC_W{1'b0}};
      os_idx_s   = {IDX_W{1'b0}};
      pending_s  = 1'b0;
      if (div_load) begin
        act_int_s  = ld_int_s;
        act_frac_s = ld_frac_s;
      end else if (pending_r) begin
        act_int_s  = sh_int_r;
        act_frac_s = sh_frac_r;
      end else begin
        act_int_s  = act_int_r;
        act_frac_s = act_frac_r;
      end
    end else begin
      // A load while running waits in the shadow registers; a later load
      // before the boundary simply overwrites them.
      if (div_load) begin
        sh_int_s  = ld_int_s;
        sh_frac_s = ld_frac_s;
        pending_s = 1'b1;
      end else begin
        sh_int_s  = sh_int_r;
        sh_frac_s = sh_frac_r;
      end

      if (period_end_s) begin
        cnt_s       = {DIV_W{1'b0}};
        frac_acc_s  = sum_s[FRAC_W-1:0];
        os_idx_s    = os_idx_r + IDX_W'(1);
        os_tick_s   = 1'b1;
        baud_tick_s = (os_idx_r == LAST_IDX);
        if (pending_r) begin
          // The shadow value being applied is the one held before this
          // cycle; a load arriving in the same cycle stays pending.
          act_int_s  = sh_int_r;
          act_frac_s = sh_frac_r;
          pending_s  = div_load;
        end else begin
          act_int_s  = act_int_r;
          act_frac_s = act_frac_r;
        end
      end else begin
        cnt_s = cnt_r + DIV_W'(1);
      end
    end
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {DIV_W{1'b0}};
      frac_acc_r  <= {FRAC_W{1'b0}};
      os_idx_r    <= {IDX_W{1'b0}};
      act_int_r   <= DEF_INT;
      act_frac_r  <= DEF_FRAC;
      sh_int_r    <= DEF_INT;
      sh_frac_r   <= DEF_FRAC;
      pending_r   <= 1'b0;
      os_tick_r   <= 1'b0;
      baud_tick_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_s;
      frac_acc_r  <= frac_acc_s;
      os_idx_r    <= os_idx_s;
      act_int_r   <= act_int_s;
      act_frac_r  <= act_frac_s;
      sh_int_r    <= sh_int_s;
      sh_frac_r   <= sh_frac_s;
      pending_r   <= pending_s;
      os_tick_r   <= os_tick_s;
      baud_tick_r <= baud_tick_s;
    end
  end

  assign div_pending = pending_r;
  assign os_tick     = os_tick_r;
  assign baud_tick   = baud_tick_r;
  assign os_idx      = os_idx_r;

`ifdef BAUD_MID_TICK_EN
  localparam logic [IDX_W-1:0] MID_PREV = IDX_W'(OVERSAMPLE / 2 - 1);

  logic mid_tick_r;

  // Bit-centre pulse: fires with the os_tick that moves os_idx to OVERSAMPLE/2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mid_tick_r <= 1'b0;
    end else if (en && !resync && period_end_s) begin
      mid_tick_r <= (os_idx_r == MID_PREV);
    end else begin
      mid_tick_r <= 1'b0;
    end
  end

  assign mid_tick = mid_tick_r;
`else
  assign mid_tick = 1'b0;
`endif

endmodule
